// File: rtl/dma_fill_verify_seq_pkg.sv
// dma_seq_pkg: shared types for the DMA fill/verify sequencer.
// Provides the FSM state encoding, run modes and mode decode helpers.
package dma_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_GO,
        WR_STREAM,
        WR_WAIT,
        RD_GO,
        RD_STREAM,
        RD_WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_FILL        = 2'd0,
        MODE_VERIFY      = 2'd1,
        MODE_FILL_VERIFY = 2'd2,
        MODE_RESERVED    = 2'd3
    } mode_t;

    // The reserved encoding behaves as FILL_VERIFY.
    function automatic logic has_fill(input mode_t m);
        return m != MODE_VERIFY;
    endfunction

    function automatic logic has_verify(input mode_t m);
        return m != MODE_FILL;
    endfunction

endpackage

// File: rtl/dma_fill_verify_seq_if.sv
// dma_fill_verify_seq_if: Avalon write/read master control and user ports.
// master = sequencer side, slave = master-core (amm_master) side.
interface dma_fill_verify_seq_if #(
    parameter int ADDRESSWIDTH = 28,
    parameter int DATAWIDTH    = 32
);
    logic                    write_control_fixed_location;
    logic [ADDRESSWIDTH-1:0] write_control_write_base;
    logic [ADDRESSWIDTH-1:0] write_control_write_length;
    logic                    write_control_go;
    logic                    write_control_done;
    logic                    write_user_write_buffer;
    logic [DATAWIDTH-1:0]    write_user_buffer_data;
    logic                    write_user_buffer_full;

    logic                    read_control_fixed_location;
    logic [ADDRESSWIDTH-1:0] read_control_read_base;
    logic [ADDRESSWIDTH-1:0] read_control_read_length;
    logic                    read_control_go;
    logic                    read_control_done;
    logic                    read_user_read_buffer;
    logic [DATAWIDTH-1:0]    read_user_buffer_output_data;
    logic                    read_user_data_available;

    modport master (
        output write_control_fixed_location,
        output write_control_write_base,
        output write_control_write_length,
        output write_control_go,
        input  write_control_done,
        output write_user_write_buffer,
        output write_user_buffer_data,
        input  write_user_buffer_full,
        output read_control_fixed_location,
        output read_control_read_base,
        output read_control_read_length,
        output read_control_go,
        input  read_control_done,
        output read_user_read_buffer,
        input  read_user_buffer_output_data,
        input  read_user_data_available
    );

    modport slave (
        input  write_control_fixed_location,
        input  write_control_write_base,
        input  write_control_write_length,
        input  write_control_go,
        output write_control_done,
        input  write_user_write_buffer,
        input  write_user_buffer_data,
        output write_user_buffer_full,
        input  read_control_fixed_location,
        input  read_control_read_base,
        input  read_control_read_length,
        input  read_control_go,
        output read_control_done,
        input  read_user_read_buffer,
        output read_user_buffer_output_data,
        output read_user_data_available
    );

endinterface

// File: rtl/dma_fill_verify_seq_pattern_gen.sv
// dma_pattern_gen: combinational test-pattern word generator.
// Ports: seed, inc, index in; word = inc ? seed+index : seed (wraps).
module dma_pattern_gen #(
    parameter int DATAWIDTH = 32,
    parameter int LENWIDTH  = 16
) (
    input  logic [DATAWIDTH-1:0] seed,
    input  logic                 inc,
    input  logic [LENWIDTH-1:0]  index,
    output logic [DATAWIDTH-1:0] word
);
    assign word = inc ? seed + DATAWIDTH'(index) : seed;
endmodule

// File: rtl/dma_fill_verify_seq.sv
// dma_fill_verify_seq: fills a DRAM region with a pattern and/or verifies it.
// Ports: clk/reset, start/mode/pattern_inc/seed/base_addr/length_words in,
// busy/done/error_count/first_err_addr out, avm = Avalon master interface.
module dma_fill_verify_seq
    import dma_seq_pkg::*;
#(
    parameter int ADDRESSWIDTH = 28,
    parameter int DATAWIDTH    = 32,
    parameter int LENWIDTH     = 16,
    parameter int ERRWIDTH     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic                    pattern_inc,
    input  logic [DATAWIDTH-1:0]    seed,
    input  logic [ADDRESSWIDTH-1:0] base_addr,
    input  logic [LENWIDTH-1:0]     length_words,
    output logic                    busy,
    output logic                    done,
    output logic [ERRWIDTH-1:0]     error_count,
    output logic [ADDRESSWIDTH-1:0] first_err_addr,
    dma_fill_verify_seq_if.master   avm
);
    localparam logic [ADDRESSWIDTH-1:0] WORD_BYTES =
        ADDRESSWIDTH'(DATAWIDTH / 8);
    localparam logic [ERRWIDTH-1:0] ERR_MAX = '1;

    state_t                  state, state_d;
    mode_t                   mode_q;
    logic                    inc_q;
    logic [DATAWIDTH-1:0]    seed_q;
    logic [ADDRESSWIDTH-1:0] base_q;
    logic [LENWIDTH-1:0]     len_q;
    logic [LENWIDTH-1:0]     wr_idx;
    logic [LENWIDTH-1:0]     rd_idx;
    logic [DATAWIDTH-1:0]    wr_word;
    logic [DATAWIDTH-1:0]    rd_word;
    logic [ADDRESSWIDTH-1:0] len_bytes;
    logic                    wr_go;
    logic                    rd_go;
    logic                    push;
    logic                    pop;
    logic                    mismatch;

    dma_pattern_gen #(
        .DATAWIDTH (DATAWIDTH),
        .LENWIDTH  (LENWIDTH)
    ) u_wr_pat (
        .seed  (seed_q),
        .inc   (inc_q),
        .index (wr_idx),
        .word  (wr_word)
    );

    dma_pattern_gen #(
        .DATAWIDTH (DATAWIDTH),
        .LENWIDTH  (LENWIDTH)
    ) u_rd_pat (
        .seed  (seed_q),
        .inc   (inc_q),
        .index (rd_idx),
        .word  (rd_word)
    );

    assign len_bytes = ADDRESSWIDTH'(len_q) * WORD_BYTES;
    assign mismatch  = avm.read_user_buffer_output_data != rd_word;

    assign avm.write_control_fixed_location = 1'b0;
    assign avm.write_control_write_base     = base_q;
    assign avm.write_control_write_length   = len_bytes;
    assign avm.write_control_go             = wr_go;
    assign avm.write_user_write_buffer      = push;
    assign avm.write_user_buffer_data       = wr_word;

    assign avm.read_control_fixed_location  = 1'b0;
    assign avm.read_control_read_base       = base_q;
    assign avm.read_control_read_length     = len_bytes;
    assign avm.read_control_go              = rd_go;
    assign avm.read_user_read_buffer        = pop;

    always_comb begin
        state_d = state;
        wr_go   = 1'b0;
        rd_go   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (length_words == '0)
                        state_d = DONE;
                    else if (has_fill(mode_t'(mode)))
                        state_d = WR_GO;
                    else
                        state_d = RD_GO;
                end
            end
            WR_GO: begin
                wr_go   = 1'b1;
                state_d = WR_STREAM;
            end
            WR_STREAM: begin
                push = !avm.write_user_buffer_full && (wr_idx < len_q);
                if (wr_idx == len_q)
                    state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (avm.write_control_done)
                    state_d = has_verify(mode_q) ? RD_GO : DONE;
            end
            RD_GO: begin
                rd_go   = 1'b1;
                state_d = RD_STREAM;
            end
            RD_STREAM: begin
                pop = avm.read_user_data_available && (rd_idx < len_q);
                if (rd_idx == len_q)
                    state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (avm.read_control_done)
                    state_d = DONE;
            end
            DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            mode_q         <= MODE_FILL;
            inc_q          <= 1'b0;
            seed_q         <= '0;
            base_q         <= '0;
            len_q          <= '0;
            wr_idx         <= '0;
            rd_idx         <= '0;
            error_count    <= '0;
            first_err_addr <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && start) begin
                mode_q <= mode_t'(mode);
                inc_q  <= pattern_inc;
                seed_q <= seed;
                base_q <= base_addr;
                len_q  <= length_words;
            end
            if (wr_go)
                wr_idx <= '0;
            else if (push)
                wr_idx <= wr_idx + LENWIDTH'(1);
            // Results of the previous verify hold until a new read phase.
            if (rd_go) begin
                rd_idx         <= '0;
                error_count    <= '0;
                first_err_addr <= '0;
            end else if (pop) begin
                rd_idx <= rd_idx + LENWIDTH'(1);
                if (mismatch) begin
                    if (error_count == '0)
                        first_err_addr <= base_q
                            + ADDRESSWIDTH'(rd_idx) * WORD_BYTES;
                    if (error_count != ERR_MAX)
                        error_count <= error_count + ERRWIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_fill_verify_seq.sv
// tb_dma_fill_verify_seq: bench for the DMA fill/verify sequencer.
// Behavioural memory/master models plus a per-cycle output checker.
`timescale 1ns/1ps
module tb_dma_fill_verify_seq;
    localparam int AW = 28;
    localparam int DW = 32;
    localparam int LW = 16;
    localparam int EW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          pattern_inc = 1'b0;
    logic [DW-1:0] seed = '0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] length_words = '0;
    logic          busy;
    logic          done;
    logic [EW-1:0] error_count;
    logic [AW-1:0] first_err_addr;

    dma_fill_verify_seq_if #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW)) avm ();

    dma_fill_verify_seq #(
        .ADDRESSWIDTH (AW),
        .DATAWIDTH    (DW),
        .LENWIDTH     (LW),
        .ERRWIDTH     (EW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .mode           (mode),
        .pattern_inc    (pattern_inc),
        .seed           (seed),
        .base_addr      (base_addr),
        .length_words   (length_words),
        .busy           (busy),
        .done           (done),
        .error_count    (error_count),
        .first_err_addr (first_err_addr),
        .avm            (avm)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Word-addressed DRAM model
    logic [DW-1:0] mem [int];

    function automatic logic [DW-1:0] mem_rd(input int a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    function automatic logic [DW-1:0] pat(input logic [DW-1:0] s,
                                          input bit inc, input int i);
        return inc ? s + DW'(i) : s;
    endfunction

    // Reference model of the current run
    bit            x_inc;
    logic [DW-1:0] x_seed;
    logic [AW-1:0] x_base;
    int            x_len;
    bit            x_fill;
    bit            x_verify;
    logic [EW-1:0] m_err = '0;
    logic [AW-1:0] m_first = '0;
    int push_cnt = 0, pop_cnt = 0, wgo_cnt = 0, rgo_cnt = 0, done_cnt = 0;
    logic [DW-1:0] pushed [$];
    logic [AW-1:0] last_wlen;
    int full_mode = 0;
    int avail_mode = 0;

    task automatic setup_model(input logic [1:0] md, input bit inc,
                               input logic [DW-1:0] sd,
                               input logic [AW-1:0] ba, input int ln);
        int e;
        logic [AW-1:0] f;
        logic [DW-1:0] w;
        x_inc = inc; x_seed = sd; x_base = ba; x_len = ln;
        x_fill = (ln != 0) && (md != 2'd1);
        x_verify = (ln != 0) && (md != 2'd0);
        push_cnt = 0; pop_cnt = 0; wgo_cnt = 0; rgo_cnt = 0; done_cnt = 0;
        pushed.delete();
        if (x_verify) begin
            e = 0;
            f = '0;
            for (int i = 0; i < ln; i++) begin
                w = x_fill ? pat(sd, inc, i) : mem_rd(int'(ba >> 2) + i);
                if (w != pat(sd, inc, i)) begin
                    if (e == 0) f = ba + AW'(4 * i);
                    e++;
                end
            end
            m_err = EW'(e);
            m_first = f;
        end
    endtask

    // Write master + FIFO model
    logic wr_done, wr_full;
    bit w_act;
    int w_word, w_cnt, w_tot, w_dly;
    assign avm.write_control_done = wr_done;
    assign avm.write_user_buffer_full = wr_full;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            w_act = 0; w_cnt = 0; w_tot = 0; w_dly = 0;
            wr_done <= 1'b0;
            wr_full <= 1'b0;
        end else begin
            if (avm.write_control_go) begin
                w_act = 1;
                w_word = int'(avm.write_control_write_base >> 2);
                w_tot = int'(avm.write_control_write_length >> 2);
                w_cnt = 0;
                w_dly = $urandom_range(0, 3);
                wr_done <= 1'b0;
            end else if (w_act) begin
                if (avm.write_user_write_buffer) begin
                    mem[w_word + w_cnt] = avm.write_user_buffer_data;
                    w_cnt++;
                end
                if (w_cnt >= w_tot) begin
                    if (w_dly == 0) begin
                        wr_done <= 1'b1;
                        w_act = 0;
                    end else w_dly--;
                end
            end
            case (full_mode)
                0: wr_full <= 1'b0;
                1: wr_full <= ~wr_full;
                default: wr_full <= ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    // Read master + show-ahead FIFO model
    logic          rd_done, rd_avail;
    logic [DW-1:0] rd_head;
    logic [DW-1:0] rq [$];
    bit r_act;
    int r_word, r_tot, r_fed;
    bit feed;
    assign avm.read_control_done = rd_done;
    assign avm.read_user_data_available = rd_avail;
    assign avm.read_user_buffer_output_data = rd_head;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            r_act = 0; r_fed = 0; r_tot = 0;
            rq.delete();
            rd_done <= 1'b0;
            rd_avail <= 1'b0;
            rd_head <= '0;
        end else begin
            if (avm.read_user_read_buffer && rq.size() != 0)
                void'(rq.pop_front());
            if (avm.read_control_go) begin
                r_act = 1;
                rq.delete();
                r_word = int'(avm.read_control_read_base >> 2);
                r_tot = int'(avm.read_control_read_length >> 2);
                r_fed = 0;
                rd_done <= 1'b0;
            end else if (r_act) begin
                case (avail_mode)
                    0: feed = 1;
                    1: feed = ($urandom_range(0, 3) == 0);
                    default: feed = ($urandom_range(0, 1) == 0);
                endcase
                if (feed && r_fed < r_tot) begin
                    rq.push_back(mem_rd(r_word + r_fed));
                    r_fed++;
                end
                if (r_fed >= r_tot && rq.size() == 0) begin
                    rd_done <= 1'b1;
                    r_act = 0;
                end
            end
            rd_avail <= (rq.size() != 0);
            rd_head <= (rq.size() != 0) ? rq[0] : '0;
        end
    end

    // Per-cycle output checker
    always @(negedge clk) begin
        if (!reset) begin
            if (avm.write_user_write_buffer) begin
                chk("push_while_full", avm.write_user_buffer_full, 0);
                chk("push_data", avm.write_user_buffer_data,
                    pat(x_seed, x_inc, push_cnt));
                chk("push_in_range", push_cnt < x_len, 1);
                pushed.push_back(avm.write_user_buffer_data);
                push_cnt++;
            end
            if (avm.read_user_read_buffer) begin
                chk("pop_while_empty", avm.read_user_data_available, 1);
                chk("pop_in_range", pop_cnt < x_len, 1);
                pop_cnt++;
            end
            if (avm.write_control_go) begin
                chk("wgo_base", avm.write_control_write_base, x_base);
                chk("wgo_len", avm.write_control_write_length,
                    AW'(x_len * 4));
                chk("wgo_fixed", avm.write_control_fixed_location, 0);
                last_wlen = avm.write_control_write_length;
                wgo_cnt++;
            end
            if (avm.read_control_go) begin
                chk("rgo_base", avm.read_control_read_base, x_base);
                chk("rgo_len", avm.read_control_read_length,
                    AW'(x_len * 4));
                chk("rgo_fixed", avm.read_control_fixed_location, 0);
                rgo_cnt++;
            end
            if (done) begin
                chk("done_pushes", push_cnt, x_fill ? x_len : 0);
                chk("done_pops", pop_cnt, x_verify ? x_len : 0);
                chk("done_wgo", wgo_cnt, x_fill ? 1 : 0);
                chk("done_rgo", rgo_cnt, x_verify ? 1 : 0);
                chk("done_err", error_count, m_err);
                chk("done_first", first_err_addr, m_first);
                chk("done_busy", busy, 0);
                done_cnt++;
            end
        end
    end

    task automatic chk_zero(input string t);
        chk({t, "_busy_done"}, {busy, done}, 0);
        chk({t, "_err"}, error_count, 0);
        chk({t, "_first"}, first_err_addr, 0);
        chk({t, "_wr_ctl"}, {avm.write_control_fixed_location,
            avm.write_control_go, avm.write_user_write_buffer}, 0);
        chk({t, "_wr_base"}, avm.write_control_write_base, 0);
        chk({t, "_wr_len"}, avm.write_control_write_length, 0);
        chk({t, "_wr_data"}, avm.write_user_buffer_data, 0);
        chk({t, "_rd_ctl"}, {avm.read_control_fixed_location,
            avm.read_control_go, avm.read_user_read_buffer}, 0);
        chk({t, "_rd_base"}, avm.read_control_read_base, 0);
        chk({t, "_rd_len"}, avm.read_control_read_length, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_err = '0;
        m_first = '0;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic start_run(input logic [1:0] md, input bit inc,
                             input logic [DW-1:0] sd,
                             input logic [AW-1:0] ba, input int ln,
                             input bit glitch);
        setup_model(md, inc, sd, ba, ln);
        @(posedge clk);
        #1;
        mode = md; pattern_inc = inc; seed = sd;
        base_addr = ba; length_words = LW'(ln); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        if (ln == 0) begin
            chk("len0_done_latency", done, 1);
        end else begin
            chk("start_busy", busy, 1);
            chk("start_go_latency", md == 2'd1 ? avm.read_control_go
                : avm.write_control_go, 1);
        end
        if (glitch) begin
            @(posedge clk);
            #1;
            start = 1'b1; mode = ~md; seed = ~sd; pattern_inc = ~inc;
            base_addr = ba + 28'h4; length_words = LW'(ln + 3);
            @(posedge clk);
            #1 start = 1'b0;
        end
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        while (done_cnt == 0 && c < 4000) begin
            @(posedge clk);
            c++;
        end
        chk("run_completes", done_cnt != 0, 1);
        if (done_cnt == 0) begin
            do_reset();
        end else begin
            @(negedge clk);
            chk("done_single_pulse", done, 0);
            chk("idle_busy", busy, 0);
            chk("done_count", done_cnt, 1);
        end
    endtask

    task automatic preload(input logic [AW-1:0] ba, input int ln,
                           input logic [DW-1:0] sd, input bit inc,
                           input int corrupt_pct);
        logic [DW-1:0] flip;
        for (int i = 0; i < ln; i++) begin
            flip = '0;
            if ($urandom_range(0, 99) < corrupt_pct)
                flip = DW'(1) << $urandom_range(0, DW - 1);
            mem[int'(ba >> 2) + i] = pat(sd, inc, i) ^ flip;
        end
    endtask

    initial begin
        int c;
        logic [1:0] md;
        int ln;
        logic [AW-1:0] ba;
        #3;
        chk_zero("por");
        @(posedge clk);
        #1 reset = 1'b0;

        // 1: FILL, incrementing pattern, no back-pressure
        full_mode = 0;
        start_run(2'd0, 1, 32'hA5A5_0000, 28'h0, 4, 0);
        wait_done();
        chk("t1_push0", pushed.size() > 0 ? pushed[0] : '0, 32'hA5A5_0000);
        chk("t1_push3", pushed.size() > 3 ? pushed[3] : '0, 32'hA5A5_0003);
        chk("t1_nwords", pushed.size(), 4);
        chk("t1_wlen", last_wlen, 28'd16);

        // pattern add wraps
        start_run(2'd0, 1, 32'hFFFF_FFFE, 28'h40, 4, 0);
        wait_done();
        chk("wrap_push2", pushed.size() > 2 ? pushed[2] : '1, 32'h0);

        // 2: full toggles every other cycle
        full_mode = 1;
        start_run(2'd0, 0, 32'h1234_5678, 28'h80, 8, 0);
        wait_done();
        chk("t2_pushes", push_cnt, 8);

        // 3: FILL_VERIFY against ideal memory
        full_mode = 2; avail_mode = 2;
        start_run(2'd2, 1, 32'hC0DE_0000, 28'h400, 16, 0);
        wait_done();
        chk("t3_err", error_count, 0);

        // 4: VERIFY with word 5 corrupted
        avail_mode = 0;
        preload(28'h100, 8, 32'h0000_1000, 1, 0);
        mem[(28'h100 >> 2) + 5] = mem[(28'h100 >> 2) + 5] ^ 32'h80;
        start_run(2'd1, 1, 32'h0000_1000, 28'h100, 8, 0);
        wait_done();
        chk("t4_err", error_count, 1);
        chk("t4_first", first_err_addr, 28'h114);

        // 5: zero length, then start while busy
        start_run(2'd2, 0, 32'h1, 28'h800, 0, 0);
        wait_done();
        chk("t5_err_held", error_count, 1);
        full_mode = 0;
        start_run(2'd0, 1, 32'h10, 28'h600, 6, 1);
        wait_done();

        // 6: reset while streaming reads
        avail_mode = 1;
        preload(28'h200, 16, 32'h0BAD_0000, 1, 0);
        start_run(2'd1, 1, 32'h0BAD_0000, 28'h200, 16, 0);
        c = 0;
        while (pop_cnt < 3 && c < 500) begin
            @(posedge clk);
            c++;
        end
        chk("t6_in_rd_stream", pop_cnt >= 3, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_zero("midrst");
        do_reset();
        avail_mode = 0;
        start_run(2'd2, 0, 32'h5A5A_1234, 28'h300, 5, 0);
        wait_done();

        // randomized runs
        for (int r = 0; r < 40; r++) begin
            md = 2'($urandom_range(0, 3));
            ln = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 24);
            ba = AW'($urandom_range(0, 1023)) << 2;
            seed = $urandom;
            full_mode = $urandom_range(0, 2);
            avail_mode = $urandom_range(0, 2);
            if (md == 2'd1)
                preload(ba, ln, seed, r[0], 15);
            start_run(md, r[0], seed, ba, ln, r % 7 == 3);
            wait_done();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
